// File: rtl/alu_flag_pkg.sv
// Shared constants for the ALU flag stage: flag bit positions, condition codes,
// skid-buffer state encoding and the condition evaluator.
package alu_flag_pkg;

   localparam int unsigned FLAGS_W = 5;

   localparam int unsigned FLAG_S = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_P = 3;
   localparam int unsigned FLAG_V = 4;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_PE = 4'd8;
   localparam logic [3:0] COND_PO = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   function automatic logic cond_eval(input logic [3:0] sel, input logic [FLAGS_W-1:0] f);
      logic s, z, c, p, v, r;
      s = f[FLAG_S];
      z = f[FLAG_Z];
      c = f[FLAG_C];
      p = f[FLAG_P];
      v = f[FLAG_V];
      r = 1'b0;
      case (sel)
         COND_EQ: r = z;
         COND_NE: r = !z;
         COND_CS: r = c;
         COND_CC: r = !c;
         COND_MI: r = s;
         COND_PL: r = !s;
         COND_VS: r = v;
         COND_VC: r = !v;
         COND_PE: r = p;
         COND_PO: r = !p;
         COND_GE: r = (s == v);
         COND_LT: r = (s != v);
         COND_GT: r = !z && (s == v);
         COND_LE: r = z || (s != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/flag_skid_buf.sv
// Two-entry valid/ready skid buffer; head entry drives the output, ready is registered.
module flag_skid_buf
   import alu_flag_pkg::*;
#(
   parameter int unsigned W = 21
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   state_q, state_d;
   logic [W-1:0] head_d, tail_q, tail_d;
   logic         push, pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Next state and entry steering; tail only ever feeds the head on a pop from TWO
   always_comb begin
      state_d = state_q;
      head_d  = out_data;
      tail_d  = tail_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               state_d = ST_ONE;
               head_d  = in_data;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               head_d = in_data;
            end else if (push) begin
               state_d = ST_TWO;
               tail_d  = in_data;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               state_d = ST_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         tail_q    <= '0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d != ST_TWO);
         out_valid <= (state_d != ST_EMPTY);
         out_data  <= head_d;
         tail_q    <= tail_d;
      end
   end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered ALU output stage: skid buffer, retired flags, branch condition and sticky overflow.
// Optional event counters enabled by defining ALU_FLAG_STATS_EN.
module alu_flag_stage
   import alu_flag_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_sum,
   input  logic [FLAGS_W-1:0] in_flags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_sum,
   output logic [FLAGS_W-1:0] out_flags,
   input  logic [3:0]         cond_sel,
   output logic               cond_true,
`ifdef ALU_FLAG_STATS_EN
   output logic [CNT_W-1:0]   ovf_count,
   output logic [CNT_W-1:0]   carry_count,
`endif
   output logic [FLAGS_W-1:0] arch_flags,
   output logic               sticky_ovf,
   input  logic               sticky_clr
);

   localparam int unsigned BUF_W = DATA_W + FLAGS_W;

   logic [BUF_W-1:0] buf_out;
   logic             retire;

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("CNT_W must be nonzero");
   end

   flag_skid_buf #(.W(BUF_W)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_flags, in_sum}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign out_sum   = buf_out[DATA_W-1:0];
   assign out_flags = buf_out[BUF_W-1:DATA_W];
   assign retire    = out_valid && out_ready;
   assign cond_true = cond_eval(cond_sel, arch_flags);

   // Retired flags and sticky overflow; a retiring overflow beats a clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arch_flags <= '0;
         sticky_ovf <= 1'b0;
      end else begin
         if (retire) begin
            arch_flags <= out_flags;
         end
         if (retire && out_flags[FLAG_V]) begin
            sticky_ovf <= 1'b1;
         end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
         end
      end
   end

`ifdef ALU_FLAG_STATS_EN
   logic ovf_inc, carry_inc;

   assign ovf_inc   = retire && out_flags[FLAG_V];
   assign carry_inc = retire && out_flags[FLAG_C];

   // Saturating counters; clear then increment in one cycle yields 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_count   <= '0;
         carry_count <= '0;
      end else begin
         if (sticky_clr) begin
            ovf_count <= CNT_W'(ovf_inc);
         end else if (ovf_inc && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
         end
         if (sticky_clr) begin
            carry_count <= CNT_W'(carry_inc);
         end else if (carry_inc && (carry_count != '1)) begin
            carry_count <= carry_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: scoreboard of pushed entries, occupancy/flag model and vector table.
// Define ALU_FLAG_STATS_EN to also exercise the saturating counters (CNT_W=2).
module tb_alu_flag_stage;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_sum;
   logic [4:0]    in_flags;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_sum;
   logic [4:0]    out_flags;
   logic [3:0]    cond_sel;
   logic          cond_true;
   logic [4:0]    arch_flags;
   logic          sticky_ovf;
   logic          sticky_clr;
`ifdef ALU_FLAG_STATS_EN
   logic [CW-1:0] ovf_count;
   logic [CW-1:0] carry_count;
`endif

   alu_flag_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_flags   (in_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_flags  (out_flags),
      .cond_sel   (cond_sel),
      .cond_true  (cond_true),
`ifdef ALU_FLAG_STATS_EN
      .ovf_count  (ovf_count),
      .carry_count(carry_count),
`endif
      .arch_flags (arch_flags),
      .sticky_ovf (sticky_ovf),
      .sticky_clr (sticky_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] sum;
      logic [4:0]    flags;
      logic [3:0]    sel;
      logic          exp;
   } vec_t;

   typedef struct {
      logic [DW-1:0] sum;
      logic [4:0]    flags;
   } ent_t;

   int   total = 0;
   int   bad   = 0;
   ent_t sb[$];
   logic [4:0] m_arch;
   logic       m_sticky;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // flags packed {v,p,c,z,s}
   function automatic logic ref_cond(input logic [3:0] sel, input logic [4:0] f);
      logic s, z, c, p, v;
      {v, p, c, z, s} = f;
      case (sel)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return s;
         4'd5:  return !s;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return p;
         4'd9:  return !p;
         4'd10: return s == v;
         4'd11: return s != v;
         4'd12: return !z && (s == v);
         4'd13: return z || (s != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: score the handshake seen before the edge, then check the state after it
   task automatic cycle();
      logic push, pop;
      ent_t e;
      @(negedge clk);
      push = (in_ready === 1'b1) && in_valid;
      pop  = (out_valid === 1'b1) && out_ready;
      if (rst_n) begin
         if (pop) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 32'(out_sum), 32'hdead);
            end else begin
               e = sb.pop_front();
               chk("out_sum", 32'(out_sum), 32'(e.sum));
               chk("out_flags", 32'(out_flags), 32'(e.flags));
               m_arch = e.flags;
            end
         end
         if (pop && m_arch[4]) m_sticky = 1'b1;
         else if (sticky_clr) m_sticky = 1'b0;
         if (push) sb.push_back('{in_sum, in_flags});
      end else begin
         sb.delete();
         m_arch   = '0;
         m_sticky = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      chk("arch_flags", 32'(arch_flags), 32'(m_arch));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
      chk("cond_true_model", 32'(cond_true), 32'(ref_cond(cond_sel, m_arch)));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 8 && sb.size() != 0; i++) cycle();
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   vec_t vt[16];

   initial begin
      m_arch = '0; m_sticky = 1'b0;
      rst_n = 1'b0; in_valid = 1'b1; in_sum = 16'h5a5a; in_flags = 5'b11111;
      out_ready = 1'b1; cond_sel = 4'd0; sticky_clr = 1'b0;

      // reset held two cycles with in_valid high
      cycle(); cycle();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_arch", 32'(arch_flags), 32'd0);
      chk("rst_sticky", 32'(sticky_ovf), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      cycle();

      // table: one entry pushed and retired, then condition checked on the new arch flags
      vt[0]  = '{16'h0fff, 5'b10100, 4'd6,  1'b1};
      vt[1]  = '{16'h0fff, 5'b10100, 4'd2,  1'b1};
      vt[2]  = '{16'h0fff, 5'b10100, 4'd10, 1'b0};
      vt[3]  = '{16'h0000, 5'b00110, 4'd0,  1'b1};
      vt[4]  = '{16'h0000, 5'b00110, 4'd1,  1'b0};
      vt[5]  = '{16'h0000, 5'b00110, 4'd13, 1'b1};
      vt[6]  = '{16'h0000, 5'b00110, 4'd12, 1'b0};
      vt[7]  = '{16'h8000, 5'b00001, 4'd4,  1'b1};
      vt[8]  = '{16'h8000, 5'b00001, 4'd11, 1'b1};
      vt[9]  = '{16'h7fff, 5'b01000, 4'd8,  1'b1};
      vt[10] = '{16'h7fff, 5'b01000, 4'd9,  1'b0};
      vt[11] = '{16'h0001, 5'b00000, 4'd14, 1'b1};
      vt[12] = '{16'h0001, 5'b00000, 4'd15, 1'b0};
      vt[13] = '{16'h0001, 5'b00000, 4'd3,  1'b1};
      vt[14] = '{16'h0001, 5'b00000, 4'd7,  1'b1};
      vt[15] = '{16'h0001, 5'b00000, 4'd12, 1'b1};
      for (int i = 0; i < 16; i++) begin
         cond_sel = vt[i].sel;
         in_sum = vt[i].sum; in_flags = vt[i].flags; in_valid = 1'b1; out_ready = 1'b1;
         cycle();
         chk("lat1_out_sum", 32'(out_sum), 32'(vt[i].sum));
         in_valid = 1'b0;
         cycle();
         chk($sformatf("cond_vec%0d", i), 32'(cond_true), 32'(vt[i].exp));
      end
      chk("sticky_after_table", 32'(sticky_ovf), 32'd1);

      // backpressure: fill both entries, third word held off until space
      out_ready = 1'b0; in_valid = 1'b1;
      in_sum = 16'hffff; in_flags = 5'b00001; cycle();
      in_sum = 16'h1234; in_flags = 5'b00000; cycle();
      chk("bp_in_ready_two", 32'(in_ready), 32'd0);
      in_sum = 16'h5555; in_flags = 5'b00100; cycle(); cycle();
      chk("bp_head_held", 32'(out_sum), 32'hffff);
      out_ready = 1'b1; cond_sel = 4'd4;
      cycle();
      chk("bp_mi", 32'(cond_true), 32'd1);
      cond_sel = 4'd5;
      cycle();
      chk("bp_pl", 32'(cond_true), 32'd1);
      in_valid = 1'b0;
      drain();

      // sticky clear alone, then clear colliding with a retiring overflow
      sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
      chk("sticky_clr_alone", 32'(sticky_ovf), 32'd0);
      in_valid = 1'b1; in_sum = 16'h0fff; in_flags = 5'b10100; cycle();
      in_valid = 1'b0; sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
      chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);

      // random traffic with random backpressure
      for (int i = 0; i < 200; i++) begin
         if (!(in_valid && !in_ready)) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sum   = 16'($urandom);
            in_flags = 5'($urandom);
         end
         out_ready  = 1'($urandom_range(0, 1));
         cond_sel   = 4'($urandom);
         sticky_clr = ($urandom_range(0, 7) == 0);
         cycle();
      end
      sticky_clr = 1'b0;
      drain();

      // reset in the middle of a transfer drops both entries without retiring
      out_ready = 1'b0; in_valid = 1'b1;
      in_sum = 16'haaaa; in_flags = 5'b10000; cycle();
      in_sum = 16'hbbbb; cycle();
      rst_n = 1'b0; in_valid = 1'b0; cycle();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sticky", 32'(sticky_ovf), 32'd0);
      rst_n = 1'b1; out_ready = 1'b1; cycle();

`ifdef ALU_FLAG_STATS_EN
      chk("cnt_rst", 32'(ovf_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_sum = 16'(i); in_flags = 5'b10000; cycle();
      end
      drain();
      chk("ovf_sat", 32'(ovf_count), 32'd3);
      chk("carry_none", 32'(carry_count), 32'd0);
      sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
      chk("ovf_clr", 32'(ovf_count), 32'd0);
      in_valid = 1'b1; in_flags = 5'b10100; cycle(); in_valid = 1'b0;
      sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
      chk("ovf_clr_inc", 32'(ovf_count), 32'd1);
      chk("carry_clr_inc", 32'(carry_count), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
